read_machine: RTL and testbench

READ_MACHINE -- requirements
Module: read_machine

---
 rtl/bus_pkg.sv | 29 ++
 rtl/bus_timeout_cnt.sv | 26 ++
 rtl/read_machine.sv | 107 ++++++++++
 tb/tb_read_machine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the read and write machines: widths, state encodings,
// strobe polarities and the address sequencing helper.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_RELEASE = 2'b10,
    ST_HOLD    = 2'b11
  } bus_state_e;

  // Bus strobes and acknowledges are active-low.
  localparam logic BUS_ASSERT   = 1'b0;
  localparam logic BUS_DEASSERT = 1'b1;

  // Sequential address with wrap from last back to base.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] last
  );
    return (addr == last) ? base : addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// REQ-phase watchdog: counts un-acknowledged request cycles and flags the last
// allowed one so the owning machine can abort the access.
module bus_timeout_cnt
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  // Fires in the cycle whose increment would reach TIMEOUT-1.
  assign expire_c = enable && (count == CNT_W'(TIMEOUT - 2));

endmodule

// File: rtl/read_machine.sv
// Read-only bus master: one address-strobed read per step_en, with a REQ-phase
// timeout and a one-word hand-off buffer towards the write machine.
module read_machine
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 32'h0000_00FF,
  parameter int unsigned       TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic              ACK_N,
  input  logic [DATA_W-1:0] DI,
  input  logic              rd_ready,
  output logic              AS_N,
  output logic              WR_N,
  output logic [ADDR_W-1:0] AO,
  output logic [DATA_W-1:0] RDO,
  output logic              rd_valid,
  output logic              in_init,
  output logic [1:0]        current_read_state_out,
  output logic              stop_n_monitor,
  output logic              err
);

  bus_state_e state, next_state;
  logic       capture, advance, timeout_hit, cnt_clear;
  logic       cnt_en_c, expire_c;

  assign cnt_en_c = (state == ST_REQ) && (ACK_N == BUS_DEASSERT);

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en_c),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state and one-cycle action strobes; ACK beats timeout in the same cycle.
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    advance     = 1'b0;
    timeout_hit = 1'b0;
    cnt_clear   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (step_en) begin
          next_state = ST_REQ;
          cnt_clear  = 1'b1;
        end
      end
      ST_REQ: begin
        if (ACK_N == BUS_ASSERT) begin
          next_state = ST_RELEASE;
          capture    = 1'b1;
        end else if (expire_c) begin
          next_state  = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (ACK_N == BUS_DEASSERT) next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (rd_ready) begin
          next_state = ST_IDLE;
          advance    = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered outputs track the state being entered so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AS_N                   <= BUS_DEASSERT;
      AO                     <= BASE_ADDR;
      RDO                    <= '0;
      rd_valid               <= 1'b0;
      in_init                <= 1'b1;
      stop_n_monitor         <= 1'b1;
      current_read_state_out <= ST_IDLE;
      err                    <= 1'b0;
    end else begin
      AS_N                   <= (next_state == ST_REQ) ? BUS_ASSERT : BUS_DEASSERT;
      rd_valid               <= (next_state == ST_HOLD);
      in_init                <= (next_state == ST_IDLE);
      stop_n_monitor         <= (next_state == ST_IDLE);
      current_read_state_out <= next_state;
      if (capture)     RDO <= DI;
      if (advance)     AO  <= next_addr(AO, BASE_ADDR, LAST_ADDR);
      if (timeout_hit) err <= 1'b1;
    end
  end

  assign WR_N = BUS_DEASSERT;

endmodule

// File: tb/tb_read_machine.sv
// Directed bench for read_machine: stimulus thread acts as bus slave and pushes
// expected {address, data} words; a monitor pops them when rd_valid rises.
module tb_read_machine;

  logic        clk, reset, step_en, ACK_N, rd_ready;
  logic [31:0] DI;
  logic        AS_N, WR_N, rd_valid, in_init, stop_n_monitor, err;
  logic [31:0] AO, RDO;
  logic [1:0]  current_read_state_out;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] held;
  logic        prev_valid = 1'b0;

  read_machine #(.BASE_ADDR(32'h0), .LAST_ADDR(32'h3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .ACK_N(ACK_N), .DI(DI),
    .rd_ready(rd_ready), .AS_N(AS_N), .WR_N(WR_N), .AO(AO), .RDO(RDO),
    .rd_valid(rd_valid), .in_init(in_init),
    .current_read_state_out(current_read_state_out),
    .stop_n_monitor(stop_n_monitor), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_as_n"}, AS_N, 1);
    check({tag, "_wr_n"}, WR_N, 1);
    check({tag, "_ao"}, AO, 32'h0);
    check({tag, "_rdo"}, RDO, 32'h0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_in_init"}, in_init, 1);
    check({tag, "_stop_n"}, stop_n_monitor, 1);
    check({tag, "_state"}, current_read_state_out, 2'b00);
  endtask

  // One full read; ack_wait = REQ cycles before ACK_N drops, hold = HOLD cycles before rd_ready.
  task automatic do_read(input int ack_wait, input logic [31:0] data, input logic [31:0] exp_addr,
                         input logic [31:0] nxt_addr, input int hold, input bit poke);
    int lat, n;
    lat = 0;
    step_en = 1'b1;
    @(negedge clk); lat++;
    step_en = 1'b0;
    n = 0;
    while (AS_N !== 1'b0 && n < 20) begin @(negedge clk); lat++; n++; end
    check("req_as_n", AS_N, 0);
    check("req_state", current_read_state_out, 2'b01);
    check("req_stop_n", stop_n_monitor, 0);
    check("req_ao", AO, exp_addr);
    repeat (ack_wait) begin @(negedge clk); lat++; end
    ACK_N = 1'b0;
    DI    = data;
    exp_q.push_back({exp_addr, data});
    @(negedge clk); lat++;
    check("release_state", current_read_state_out, 2'b10);
    check("release_as_n", AS_N, 1);
    ACK_N = 1'b1;
    DI    = ~data;
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin @(negedge clk); lat++; n++; end
    check("rd_valid_rise", rd_valid, 1);
    check("latency", lat, 3 + ack_wait);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        step_en = (i == 3);
        ACK_N   = (i == 5) ? 1'b0 : 1'b1;
        DI      = 32'h0BAD_0BAD;
      end
      @(negedge clk);
      if (poke) check("hold_no_as", AS_N, 1);
    end
    step_en  = 1'b0;
    ACK_N    = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check("after_hold_valid", rd_valid, 0);
    check("after_hold_ao", AO, nxt_addr);
    check("after_hold_in_init", in_init, 1);
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        check("no_queued_step", AS_N, 1);
      end
    end
  endtask

  // ACK_N never arrives: expect abort after 15 REQ cycles with AO and RDO untouched.
  task automatic do_timeout(input logic [31:0] exp_addr, input logic [31:0] exp_rdo);
    int n;
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    n = 0;
    while (AS_N === 1'b0 && n < 40) begin @(negedge clk); n++; end
    check("timeout_req_cycles", n, 15);
    check("timeout_err", err, 1);
    check("timeout_ao", AO, exp_addr);
    check("timeout_rdo", RDO, exp_rdo);
    check("timeout_state", current_read_state_out, 2'b00);
    check("timeout_rd_valid", rd_valid, 0);
  endtask

  initial begin
    reset = 1'b1; step_en = 1'b0; ACK_N = 1'b1; rd_ready = 1'b0; DI = 32'h0;
    fork
      begin : stim
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        // ACK_N low while idle must not start or capture anything
        ACK_N = 1'b0; DI = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("idle_ack_state", current_read_state_out, 2'b00);
        check("idle_ack_rdo", RDO, 32'h0);
        ACK_N = 1'b1;
        check("pre_timeout_err", err, 0);
        do_timeout(32'h0, 32'h0);
        do_read(0, 32'hDEAD_BEEF, 32'h0, 32'h1, 0, 1'b0);
        check("err_sticky", err, 1);
        // second reset clears err, then a wrapping sequence on LAST_ADDR=3
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset2");
        reset = 1'b0;
        @(negedge clk);
        do_read(0,  32'h1111_1111, 32'h0, 32'h1, 0,  1'b0);
        do_read(14, 32'h2222_2222, 32'h1, 32'h2, 1,  1'b0);
        check("late_ack_no_err", err, 0);
        do_read(0,  32'h3333_3333, 32'h2, 32'h3, 10, 1'b1);
        do_read(2,  32'h4444_4444, 32'h3, 32'h0, 2,  1'b0);
        do_read(1,  32'h5555_5555, 32'h0, 32'h1, 0,  1'b0);
        // reset in the middle of REQ with ACK_N already low
        step_en = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
        check("mid_req_as_n", AS_N, 0);
        ACK_N = 1'b0; DI = 32'hBADC_0DE0;
        #2 reset = 1'b1;
        #1;
        check("mid_reset_as_n", AS_N, 1);
        check("mid_reset_valid", rd_valid, 0);
        check("mid_reset_ao", AO, 32'h0);
        check("mid_reset_state", current_read_state_out, 2'b00);
        check("mid_reset_rdo", RDO, 32'h0);
        ACK_N = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_read(0, 32'hCAFE_F00D, 32'h0, 32'h1, 1, 1'b0);
        repeat (2) @(negedge clk);
      end
      begin : mon
        forever begin
          @(negedge clk);
          if (rd_valid === 1'b1) begin
            if (!prev_valid) begin
              if (exp_q.size() == 0) check("unexpected_rd_valid", rd_valid, 0);
              else begin
                e = exp_q.pop_front();
                check("mon_addr", AO, e[63:32]);
                check("mon_data", RDO, e[31:0]);
              end
              held = RDO;
            end else check("mon_rdo_stable", RDO, held);
          end
          prev_valid = (rd_valid === 1'b1);
        end
      end
      begin : watchdog
        #200000;
        check("watchdog_expired", 1, 0);
      end
    join_any
    disable fork;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
